tlp_action_queue: RTL and testbench
===================================

Name: tlp_action_queue

Overview:
Parametrised action queue between the TLP receiver (producer, no ready) and the TLP sender (consumer, valid/ready).
Adds what a plain buffer lacks: configurable depth, receive throttling with headroom for actions already in the receiver pipeline, overflow detection with drop counting, high-water tracking, and a synchronous flush.
rxGate_out is ANDed externally with the receiver's own ready to form the link-level rx ready.

Parameters:
ACT_WIDTH, 64, bits per action word
DEPTH, 8, queue entries; power of two, >= 2
HEADROOM, 2, free slots reserved for in-flight actions; must satisfy 0 <= HEADROOM < DEPTH (elaboration error otherwise)
CNT_WIDTH, 16, width of the drop counter

Ports:
pcieClk_in  in  1  125MHz PCIe core clock
pcieResetN_in  in  1  asynchronous, active-low reset
flush_in  in  1  synchronous flush; empties the queue
actData_in  in  ACT_WIDTH  action from receiver
actValid_in  in  1  push strobe; no ready, always offered
actData_out  out  ACT_WIDTH  head action to sender
actValid_out  out  1  queue non-empty
actReady_in  in  1  sender accepts head
rxGate_out  out  1  high when free slots > HEADROOM
depth_out  out  $clog2(DEPTH)+1  current occupancy
highWater_out  out  $clog2(DEPTH)+1  max occupancy since reset
overflow_out  out  1  sticky; a push was dropped
dropCount_out  out  CNT_WIDTH  dropped pushes, saturating

Behaviour:
- Reset (async assert, sync release): actValid_out=0, depth_out=0, highWater_out=0, overflow_out=0, dropCount_out=0, rxGate_out=1, read/write pointers=0; actData_out don't-care.
- Storage: DEPTH x ACT_WIDTH register array; pointers $clog2(DEPTH) bits, wrapping naturally DEPTH-1 -> 0; occupancy counter separate from the pointers.
- Push accepted on cycle N when actValid_in and (depth<DEPTH or pop on N). Head visible on N+1 when previously empty (one-cycle latency, first-word fall-through); no combinational in->out path.
- Pop: actValid_out & actReady_in; next entry presented the following cycle. actReady_in with the queue empty has no effect.
- Simultaneous push+pop: depth unchanged; legal at full (push takes the freed slot) and at depth 1 (new word becomes head on N+1).
- Push at full without pop: data discarded, state unchanged; overflow_out=1 from N+1 and stays set until reset; dropCount_out increments, holding at 2^CNT_WIDTH-1.
- rxGate_out registered from next-state depth: rxGate_out(N+1) = (DEPTH - depth_next) > HEADROOM.
- highWater_out(N+1) = max(highWater_out, depth_next). Flush does not clear it.
- flush_in beats everything on the same cycle. Pointers and depth go to 0, actValid_out=0 next cycle, rxGate_out=1.
- A push coinciding with flush is discarded and not counted as a drop. Flush does not clear overflow_out or dropCount_out.
- Reset mid-transfer: all contents lost and outputs return to reset values immediately (asynchronous).

Test Plan:
(DEPTH=4, HEADROOM=1, ACT_WIDTH=64, CNT_WIDTH=4 unless stated)
- Reset, push 0xA1 with actReady_in=0 -> actValid_out=1 next cycle, actData_out=0xA1, depth_out=1, highWater_out=1, rxGate_out=1.
- Push 0xB0..0xB3 back-to-back, no pops -> depth_out 1,2,3,4. rxGate_out falls the cycle after the 3rd push (free=1). highWater_out=4. Drain yields B0,B1,B2,B3 in order, and rxGate_out rises when depth_out reaches 2.
- At full, push 0xC0 without pop 20 times -> overflow_out=1, dropCount_out saturates at 15, contents unchanged. Then push 0xC1 with a pop the same cycle -> accepted, depth_out stays 4, 0xC1 read out last.
- Continuous push+pop for 10 cycles from depth 1 -> depth_out constant 1, outputs in order, pointers wrap with no loss.
- Depth 3 with flush_in and a push on the same cycle -> depth_out=0 and actValid_out=0 next cycle, rxGate_out=1, dropCount_out unchanged, highWater_out retained.
- Assert pcieResetN_in low mid-drain, asynchronously between clock edges -> all outputs return to reset values before the next edge. Normal operation resumes after release.

Source files
------------

// File: rtl/tlp_action_queue_if.sv
// Action handshake bundle between TLP receiver, action queue and TLP sender.
interface tlp_action_queue_if #(
    parameter int unsigned ACT_WIDTH = 64
);
    logic [ACT_WIDTH-1:0] actData_in;
    logic                 actValid_in;
    logic [ACT_WIDTH-1:0] actData_out;
    logic                 actValid_out;
    logic                 actReady_in;
    logic                 rxGate_out;

    // Queue side: accepts pushes, presents the head, drives the rx gate.
    modport slave (
        input  actData_in,
        input  actValid_in,
        input  actReady_in,
        output actData_out,
        output actValid_out,
        output rxGate_out
    );

    // Environment side: receiver pushes, sender pops.
    modport master (
        output actData_in,
        output actValid_in,
        output actReady_in,
        input  actData_out,
        input  actValid_out,
        input  rxGate_out
    );
endinterface

// File: rtl/tlp_action_queue.sv
// Action queue between TLP receiver and sender: throttled, overflow-counting,
// high-water tracking FIFO with synchronous flush and registered outputs.
module tlp_action_queue #(
    parameter int unsigned ACT_WIDTH = 64,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned HEADROOM  = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                     pcieClk_in,
    input  logic                     pcieResetN_in,
    input  logic                     flush_in,
    tlp_action_queue_if.slave        act,
    output logic [$clog2(DEPTH):0]   depth_out,
    output logic [$clog2(DEPTH):0]   highWater_out,
    output logic                     overflow_out,
    output logic [CNT_WIDTH-1:0]     dropCount_out
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned DEP_W = PTR_W + 1;

    // Reject parameter sets the queue cannot implement.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("tlp_action_queue: DEPTH must be a power of two >= 2");
    end
    if (HEADROOM >= DEPTH) begin : gBadHeadroom
        $error("tlp_action_queue: HEADROOM must be below DEPTH");
    end

    logic [ACT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     rdPtr;
    logic [PTR_W-1:0]     wrPtr;

    logic                 popC;
    logic                 pushC;
    logic                 dropC;
    logic                 writeC;
    logic [PTR_W-1:0]     rdPtrNext;
    logic [PTR_W-1:0]     wrPtrNext;
    logic [DEP_W-1:0]     depthNext;
    logic [DEP_W-1:0]     highWaterNext;
    logic [ACT_WIDTH-1:0] headNext;
    logic                 gateNext;
    logic                 overflowNext;
    logic [CNT_WIDTH-1:0] dropCountNext;

    // Next-state for pointers, occupancy and status; flush overrides traffic.
    always_comb begin
        popC          = act.actValid_out & act.actReady_in;
        pushC         = act.actValid_in & ((depth_out < DEP_W'(DEPTH)) | popC);
        dropC         = act.actValid_in & ~pushC;
        writeC        = pushC & ~flush_in;
        rdPtrNext     = rdPtr;
        wrPtrNext     = wrPtr;
        depthNext     = depth_out;
        overflowNext  = overflow_out;
        dropCountNext = dropCount_out;

        if (flush_in) begin
            rdPtrNext = '0;
            wrPtrNext = '0;
            depthNext = '0;
        end else begin
            if (popC) begin
                rdPtrNext = rdPtr + PTR_W'(1);
            end
            if (pushC) begin
                wrPtrNext = wrPtr + PTR_W'(1);
            end
            depthNext = depth_out + DEP_W'(pushC) - DEP_W'(popC);
            if (dropC) begin
                overflowNext = 1'b1;
                if (dropCount_out != '1) begin
                    dropCountNext = dropCount_out + CNT_WIDTH'(1);
                end
            end
        end

        // The word being written becomes the head when it lands at the new read slot.
        headNext      = (writeC && (wrPtr == rdPtrNext)) ? act.actData_in : mem[rdPtrNext];
        gateNext      = depthNext < DEP_W'(DEPTH - HEADROOM);
        highWaterNext = (depthNext > highWater_out) ? depthNext : highWater_out;
    end

    // Storage array; contents need no reset since occupancy qualifies them.
    always_ff @(posedge pcieClk_in) begin
        if (writeC) begin
            mem[wrPtr] <= act.actData_in;
        end
    end

    // Pointer, occupancy and registered-output state.
    always_ff @(posedge pcieClk_in or negedge pcieResetN_in) begin
        if (!pcieResetN_in) begin
            rdPtr            <= '0;
            wrPtr            <= '0;
            depth_out        <= '0;
            highWater_out    <= '0;
            overflow_out     <= 1'b0;
            dropCount_out    <= '0;
            act.actValid_out <= 1'b0;
            act.actData_out  <= '0;
            act.rxGate_out   <= 1'b1;
        end else begin
            rdPtr            <= rdPtrNext;
            wrPtr            <= wrPtrNext;
            depth_out        <= depthNext;
            highWater_out    <= highWaterNext;
            overflow_out     <= overflowNext;
            dropCount_out    <= dropCountNext;
            act.actValid_out <= depthNext != '0;
            act.actData_out  <= headNext;
            act.rxGate_out   <= gateNext;
        end
    end
endmodule

// File: tb/tb_tlp_action_queue.sv
// Self-checking bench for tlp_action_queue: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_tlp_action_queue;
    localparam int unsigned ACT_WIDTH = 64;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned HEADROOM  = 1;
    localparam int unsigned CNT_WIDTH = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic [2:0]            depthO;
    logic [2:0]            hwO;
    logic                  ovfO;
    logic [CNT_WIDTH-1:0]  dropsO;

    tlp_action_queue_if #(.ACT_WIDTH(ACT_WIDTH)) bus ();

    tlp_action_queue #(
        .ACT_WIDTH(ACT_WIDTH),
        .DEPTH    (DEPTH),
        .HEADROOM (HEADROOM),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .pcieClk_in   (clk),
        .pcieResetN_in(rst_n),
        .flush_in     (flush),
        .act          (bus.slave),
        .depth_out    (depthO),
        .highWater_out(hwO),
        .overflow_out (ovfO),
        .dropCount_out(dropsO)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] mq[$];
    int          mHw;
    bit          mOvf;
    int          mDrops;
    bit          mGate;
    logic [63:0] drained[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated by the rules on each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mHw    = 0;
            mOvf   = 0;
            mDrops = 0;
            mGate  = 1;
        end else begin
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && bus.actReady_in) void'(mq.pop_front());
                if (bus.actValid_in) begin
                    if (mq.size() < DEPTH) mq.push_back(bus.actData_in);
                    else begin
                        mOvf = 1;
                        if (mDrops < (1 << CNT_WIDTH) - 1) mDrops++;
                    end
                end
            end
            if (mq.size() > mHw) mHw = mq.size();
            mGate = (int'(DEPTH) - mq.size()) > int'(HEADROOM);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", 64'(bus.actValid_out), 64'(mq.size() > 0));
            if (mq.size() > 0) chk("m_data", bus.actData_out, mq[0]);
            chk("m_depth", 64'(depthO), 64'(mq.size()));
            chk("m_hw", 64'(hwO), 64'(mHw));
            chk("m_ovf", 64'(ovfO), 64'(mOvf));
            chk("m_drops", 64'(dropsO), 64'(mDrops));
            chk("m_gate", 64'(bus.rxGate_out), 64'(mGate));
        end
    end

    task automatic step(input bit v, input logic [63:0] d, input bit r, input bit f);
        bus.actValid_in = v;
        bus.actData_in  = d;
        bus.actReady_in = r;
        flush           = f;
        if (bus.actValid_out && r) drained.push_back(bus.actData_out);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chkDrained(input string name, input logic [63:0] first, input int n, input logic [63:0] last);
        chk({name, "_cnt"}, 64'(drained.size()), 64'(n));
        for (int i = 0; i < n && i < drained.size(); i++) begin
            if (i == n - 1) chk({name, "_last"}, drained[i], last);
            else            chk({name, "_ord"}, drained[i], first + 64'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.actValid_in = 1'b0;
        bus.actData_in  = '0;
        bus.actReady_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.actValid_out), 64'd0);
        chk("rst_depth", 64'(depthO), 64'd0);
        chk("rst_hw", 64'(hwO), 64'd0);
        chk("rst_ovf", 64'(ovfO), 64'd0);
        chk("rst_drops", 64'(dropsO), 64'd0);
        chk("rst_gate", 64'(bus.rxGate_out), 64'd1);
        rst_n = 1'b1;
        step(0, 0, 0, 0);

        // Single push, first-word fall-through.
        step(1, 64'hA1, 0, 0);
        chk("a1_valid", 64'(bus.actValid_out), 64'd1);
        chk("a1_data", bus.actData_out, 64'hA1);
        chk("a1_depth", 64'(depthO), 64'd1);
        chk("a1_hw", 64'(hwO), 64'd1);
        chk("a1_gate", 64'(bus.rxGate_out), 64'd1);
        step(0, 0, 1, 0);
        chk("a1_pop_depth", 64'(depthO), 64'd0);

        // Fill to full; gate drops once one free slot remains.
        step(1, 64'hB0, 0, 0);
        chk("b_d1", 64'(depthO), 64'd1);
        step(1, 64'hB1, 0, 0);
        chk("b_d2", 64'(depthO), 64'd2);
        chk("b_gate2", 64'(bus.rxGate_out), 64'd1);
        step(1, 64'hB2, 0, 0);
        chk("b_d3", 64'(depthO), 64'd3);
        chk("b_gate3", 64'(bus.rxGate_out), 64'd0);
        step(1, 64'hB3, 0, 0);
        chk("b_d4", 64'(depthO), 64'd4);
        chk("b_hw4", 64'(hwO), 64'd4);

        // Overflow with saturating drop count.
        repeat (20) step(1, 64'hC0, 0, 0);
        chk("c_ovf", 64'(ovfO), 64'd1);
        chk("c_drops", 64'(dropsO), 64'd15);
        chk("c_depth", 64'(depthO), 64'd4);
        chk("c_head", bus.actData_out, 64'hB0);
        drained.delete();
        step(1, 64'hC1, 1, 0);
        chk("c1_depth", 64'(depthO), 64'd4);
        chk("c1_head", bus.actData_out, 64'hB1);
        step(0, 0, 1, 0);
        chk("dr_gate3", 64'(bus.rxGate_out), 64'd0);
        step(0, 0, 1, 0);
        chk("dr_gate2", 64'(bus.rxGate_out), 64'd1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("dr_valid", 64'(bus.actValid_out), 64'd0);
        chkDrained("drain_b", 64'hB0, 5, 64'hC1);

        // Streaming push+pop at depth 1 across pointer wrap.
        drained.delete();
        step(1, 64'hD0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 64'hD0 + 64'(i), 1, 0);
            chk("d_depth", 64'(depthO), 64'd1);
        end
        step(0, 0, 1, 0);
        chkDrained("drain_d", 64'hD0, 11, 64'hDA);

        // Asynchronous reset in the middle of a drain.
        step(1, 64'h10, 0, 0);
        step(1, 64'h11, 0, 0);
        step(1, 64'h12, 0, 0);
        step(0, 0, 1, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.actValid_out), 64'd0);
        chk("ar_depth", 64'(depthO), 64'd0);
        chk("ar_hw", 64'(hwO), 64'd0);
        chk("ar_ovf", 64'(ovfO), 64'd0);
        chk("ar_drops", 64'(dropsO), 64'd0);
        chk("ar_gate", 64'(bus.rxGate_out), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);

        // Flush at depth 3 with a coincident push.
        step(1, 64'hE0, 0, 0);
        step(1, 64'hE1, 0, 0);
        step(1, 64'hE2, 0, 0);
        step(1, 64'hE9, 0, 1);
        chk("f3_depth", 64'(depthO), 64'd0);
        chk("f3_valid", 64'(bus.actValid_out), 64'd0);
        chk("f3_gate", 64'(bus.rxGate_out), 64'd1);
        chk("f3_drops", 64'(dropsO), 64'd0);
        chk("f3_hw", 64'(hwO), 64'd3);

        // Flush at full with a push: not a drop, overflow retained.
        for (int i = 0; i < 4; i++) step(1, 64'hF0 + 64'(i), 0, 0);
        step(1, 64'hF4, 0, 0);
        chk("ff_drops1", 64'(dropsO), 64'd1);
        step(1, 64'hF5, 0, 1);
        chk("ff_depth", 64'(depthO), 64'd0);
        chk("ff_drops", 64'(dropsO), 64'd1);
        chk("ff_ovf", 64'(ovfO), 64'd1);
        chk("ff_hw", 64'(hwO), 64'd4);

        // Normal operation after flush.
        step(1, 64'h77, 0, 0);
        chk("g_data", bus.actData_out, 64'h77);
        chk("g_depth", 64'(depthO), 64'd1);
        step(0, 0, 1, 0);
        chk("g_empty", 64'(bus.actValid_out), 64'd0);
        step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
